tdp_ram_be: RTL

//  Parametrised true dual-port synchronous RAM, the successor to the fixed 64x8 dual-port RAM.

---
 rtl/tdp_ram_pkg.sv | 24 ++
 rtl/tdp_ram_port_out.sv | 72 +++++++
 rtl/tdp_ram_be.sv | 138 +++++++++++++
 3 files changed

// File: rtl/tdp_ram_pkg.sv
// Shared constants and the byte-merge helper for the true dual-port RAM.
// be_merge works on the widest supported word; callers zero-extend and slice.
package tdp_ram_pkg;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;
   localparam int RDW_NO_CHANGE   = 2;

   localparam int MAX_DATA_W = 512;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   typedef logic [MAX_DATA_W-1:0] word_t;
   typedef logic [MAX_BE_W-1:0]   be_t;

   function automatic word_t be_merge(input word_t old_word, input word_t new_word, input be_t be);
      word_t res;
      res = old_word;
      for (int i = 0; i < MAX_BE_W; i++) begin
         if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/tdp_ram_port_out.sv
// Per-port read path: read-during-write select, valid pipeline and optional
// second output register. Inputs are the pre-write word and this port's merged word.
module tdp_ram_port_out
   import tdp_ram_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int RDW_MODE = RDW_READ_FIRST,
   parameter int OUT_REG  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic [DATA_W-1:0] old_word,
   input  logic [DATA_W-1:0] new_word,
   output logic [DATA_W-1:0] dout,
   output logic              vld
);

   logic              take;
   logic [DATA_W-1:0] sel_word;
   logic [DATA_W-1:0] d1;
   logic              v1;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      take     = en;
      sel_word = old_word;
      if (en && we) begin
         case (RDW_MODE)
            RDW_WRITE_FIRST: sel_word = new_word;
            RDW_NO_CHANGE:   take     = 1'b0;
            default:         sel_word = old_word;
         endcase
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d1 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= take;
         if (take) d1 <= sel_word;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_W-1:0] d2;
         logic              v2;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               d2 <= '0;
               v2 <= 1'b0;
            end else begin
               v2 <= v1;
               if (v1) d2 <= d1;
            end
         end

         assign dout = d2;
         assign vld  = v2;
      end else begin : g_direct
         assign dout = d1;
         assign vld  = v1;
      end
   endgenerate

endmodule

// File: rtl/tdp_ram_be.sv
// True dual-port synchronous RAM with byte enables, selectable read-during-write,
// deterministic same-address write resolution and collision flags.
module tdp_ram_be
   import tdp_ram_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 6,
   parameter int BE_W     = DATA_W / 8,
   parameter int RDW_MODE = RDW_READ_FIRST,
   parameter int OUT_REG  = 0,
   parameter int WR_PRI   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_a,
   input  logic              we_a,
   input  logic [BE_W-1:0]   be_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] din_a,
   output logic [DATA_W-1:0] dout_a,
   output logic              vld_a,
   input  logic              en_b,
   input  logic              we_b,
   input  logic [BE_W-1:0]   be_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] din_b,
   output logic [DATA_W-1:0] dout_b,
   output logic              vld_b,
   output logic              wr_coll,
   output logic              rw_coll
);

   localparam int DEPTH = 1 << ADDR_W;

   generate
      if ((DATA_W % 8 != 0) || (BE_W * 8 != DATA_W) || (DATA_W > MAX_DATA_W)) begin : g_bad_width
         $error("tdp_ram_be: DATA_W must be a multiple of 8, at most MAX_DATA_W, with BE_W left derived");
      end
   endgenerate

   function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [BE_W-1:0]   be);
      word_t o;
      word_t n;
      word_t r;
      be_t   b;
      o = '0;
      n = '0;
      b = '0;
      o[DATA_W-1:0] = old_word;
      n[DATA_W-1:0] = new_word;
      b[BE_W-1:0]   = be;
      r = be_merge(o, n, b);
      return r[DATA_W-1:0];
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr_a;
   logic              wr_b;
   logic              same_addr;
   logic              wr_wr_same;
   logic [DATA_W-1:0] old_a;
   logic [DATA_W-1:0] old_b;
   logic [DATA_W-1:0] new_a;
   logic [DATA_W-1:0] new_b;
   logic [DATA_W-1:0] coll_word;

   // Writes are blocked while reset is high; reads still flow to the (reset) output regs.
   assign wr_a       = en_a & we_a & ~rst;
   assign wr_b       = en_b & we_b & ~rst;
   assign same_addr  = (addr_a == addr_b);
   assign wr_wr_same = wr_a & wr_b & same_addr;

   assign old_a = mem[addr_a];
   assign old_b = mem[addr_b];
   assign new_a = merge_word(old_a, din_a, be_a);
   assign new_b = merge_word(old_b, din_b, be_b);

   // Same-address double write: apply the losing port first, then the winner on top.
   always_comb begin
      coll_word = new_a;
      if (WR_PRI == 0) coll_word = merge_word(new_b, din_a, be_a);
      else             coll_word = merge_word(new_a, din_b, be_b);
   end

   // NOTE: the storage array has no reset so it maps onto block RAM; contents survive rst.
   always_ff @(posedge clk) begin
      if (wr_wr_same) begin
         mem[addr_a] <= coll_word;
      end else begin
         if (wr_a) mem[addr_a] <= new_a;
         if (wr_b) mem[addr_b] <= new_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_coll <= 1'b0;
         rw_coll <= 1'b0;
      end else begin
         wr_coll <= en_a & we_a & en_b & we_b & same_addr & (|(be_a & be_b));
         rw_coll <= en_a & en_b & same_addr & (we_a ^ we_b);
      end
   end

   tdp_ram_port_out #(
      .DATA_W   (DATA_W),
      .RDW_MODE (RDW_MODE),
      .OUT_REG  (OUT_REG)
   ) u_port_a (
      .clk      (clk),
      .rst      (rst),
      .en       (en_a),
      .we       (we_a),
      .old_word (old_a),
      .new_word (new_a),
      .dout     (dout_a),
      .vld      (vld_a)
   );

   tdp_ram_port_out #(
      .DATA_W   (DATA_W),
      .RDW_MODE (RDW_MODE),
      .OUT_REG  (OUT_REG)
   ) u_port_b (
      .clk      (clk),
      .rst      (rst),
      .en       (en_b),
      .we       (we_b),
      .old_word (old_b),
      .new_word (new_b),
      .dout     (dout_b),
      .vld      (vld_b)
   );

endmodule
